// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the sync/valid bundle carried through the delay pipeline.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W = 10;
  localparam int RGB_W = 4;

  typedef struct packed {
    logic hs;
    logic vs;
    logic valid;
  } sync_t;

  // Idle pattern: syncs inactive (high), nothing visible.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, valid: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register with enable; async active-low clear loads RST_VAL into every stage.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= {DEPTH{RST_VAL}};
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel-rate divider, H/V counters, sync/valid delay and RGB output register.
// Optional `VGA_FRAME_CNT_EN adds frame_start/frame_cnt for game-tick timing.
module vga_scan_gen #(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 2,
  parameter int H_VIS    = vga_timing_pkg::H_VIS,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_VIS    = vga_timing_pkg::V_VIS,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pix_data,
  output logic        pix_tick,
  output logic [9:0]  vga_h,
  output logic [9:0]  vga_v,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);
  import vga_timing_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SS  = H_VIS + H_FP;
  localparam int H_SE  = H_SS + H_SYNC - 1;
  localparam int V_SS  = V_VIS + V_FP;
  localparam int V_SE  = V_SS + V_SYNC - 1;

  logic [DIV_W-1:0]   div;
  logic               h_last, v_last, frame_wrap;
  sync_t              raw, dly;
  logic [3*RGB_W-1:0] rgb;

  // pix_tick is registered one count early so it is high while div == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= (div == DIV_W'(CLK_DIV-1)) ? '0 : div + 1'b1;
      pix_tick <= (div == DIV_W'(CLK_DIV-2));
    end
  end

  assign h_last = (vga_h == 10'(H_TOT-1));
  assign v_last = (vga_v == 10'(V_TOT-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_h <= '0;
      vga_v <= '0;
    end else if (pix_tick) begin
      vga_h <= h_last ? '0 : vga_h + 10'd1;
      if (h_last) vga_v <= v_last ? '0 : vga_v + 10'd1;
    end
  end

  assign valid     = (vga_h < 10'(H_VIS)) && (vga_v < 10'(V_VIS));
  assign raw.hs    = !((vga_h >= 10'(H_SS)) && (vga_h <= 10'(H_SE)));
  assign raw.vs    = !((vga_v >= 10'(V_SS)) && (vga_v <= 10'(V_SE)));
  assign raw.valid = valid;

  // Matches the address-logic + ROM latency so sync lines up with returning colour.
  vga_sync_delay #(
    .DEPTH  (PIPE_LAT),
    .WIDTH  ($bits(sync_t)),
    .RST_VAL(SYNC_IDLE)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .en  (pix_tick),
    .din (raw),
    .dout(dly)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pix_tick) begin
      hsync <= dly.hs;
      vsync <= dly.vs;
      rgb   <= dly.valid ? pix_data : '0;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;
  assign frame_wrap = pix_tick && h_last && v_last;

`ifdef VGA_FRAME_CNT_EN
  assign frame_start = frame_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            frame_cnt <= '0;
    else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen using a reduced 36x13 raster so full lines and frames stay short.
module tb_vga_scan_gen;

  localparam int CLK_DIV = 4;
  localparam int PL      = 2;
  localparam int HV = 20, HF = 4, HS = 8, HB = 4;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;  // 36, hsync low for h in [24,31]
  localparam int VT = VV + VF + VS + VB;  // 13, vsync low for v in [8,9]

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pix_data = 12'h000;
  logic        pix_tick, valid, hsync, vsync;
  logic [9:0]  vga_h, vga_v;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic        frame_start;
  logic [15:0] frame_cnt;
`endif

  vga_scan_gen #(
    .CLK_DIV(CLK_DIV), .PIPE_LAT(PL),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_tick(pix_tick),
    .vga_h(vga_h), .vga_v(vga_v), .valid(valid), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(frame_start), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          ticks  = 0;
  bit          rom_en = 1'b1;
  logic [11:0] hist [0:3];

  typedef struct {
    int          tk;
    logic [9:0]  h, v;
    logic        vld, hs, vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rom(input logic [9:0] h, input logic [9:0] v);
    return {h[3:0], v[3:0], 4'hA};
  endfunction

  function automatic logic [11:0] rgb_out();
    return {vga_r, vga_g, vga_b};
  endfunction

  // Advance to 1 time unit after the next pix_tick edge; emulate a ROM with PL ticks of latency.
  task automatic next_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4*CLK_DIV && !seen; i++) begin
      @(negedge clk);
      if (pix_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL tick_timeout: got no pix_tick, expected one within %0d clk", 4*CLK_DIV);
    end
    @(posedge clk); #1;
    ticks++;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = rom(vga_h, vga_v);
    if (rom_en) pix_data = hist[PL];
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst      = 1'b1;
    ticks    = 0;
    hist[0]  = rom(10'd0, 10'd0);
    hist[1]  = 12'h000;
    hist[2]  = 12'h000;
    hist[3]  = 12'h000;
    pix_data = 12'h000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, tk_cnt, first_low, last_tk, sp_err, vs_low, n_fff, n_other, wraps, runt;
    // tick, h, v, valid, hsync, vsync, rgb -- outputs reflect coordinate (tick-3)
    tbl = '{
      '{  1, 10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 12'h000},
      '{  2, 10'd2,  10'd0,  1'b1, 1'b1, 1'b1, 12'h000},
      '{  3, 10'd3,  10'd0,  1'b1, 1'b1, 1'b1, 12'h00A},
      '{  4, 10'd4,  10'd0,  1'b1, 1'b1, 1'b1, 12'h10A},
      '{ 18, 10'd18, 10'd0,  1'b1, 1'b1, 1'b1, 12'hF0A},
      '{ 19, 10'd19, 10'd0,  1'b1, 1'b1, 1'b1, 12'h00A},
      '{ 20, 10'd20, 10'd0,  1'b0, 1'b1, 1'b1, 12'h10A},
      '{ 22, 10'd22, 10'd0,  1'b0, 1'b1, 1'b1, 12'h30A},
      '{ 23, 10'd23, 10'd0,  1'b0, 1'b1, 1'b1, 12'h000},
      '{ 26, 10'd26, 10'd0,  1'b0, 1'b1, 1'b1, 12'h000},
      '{ 27, 10'd27, 10'd0,  1'b0, 1'b0, 1'b1, 12'h000},
      '{ 34, 10'd34, 10'd0,  1'b0, 1'b0, 1'b1, 12'h000},
      '{ 35, 10'd35, 10'd0,  1'b0, 1'b1, 1'b1, 12'h000},
      '{ 36, 10'd0,  10'd1,  1'b1, 1'b1, 1'b1, 12'h000},
      '{ 39, 10'd3,  10'd1,  1'b1, 1'b1, 1'b1, 12'h01A},
      '{216, 10'd0,  10'd6,  1'b0, 1'b1, 1'b1, 12'h000},
      '{219, 10'd3,  10'd6,  1'b0, 1'b1, 1'b1, 12'h000},
      '{291, 10'd3,  10'd8,  1'b0, 1'b1, 1'b0, 12'h000},
      '{362, 10'd2,  10'd10, 1'b0, 1'b1, 1'b0, 12'h000},
      '{363, 10'd3,  10'd10, 1'b0, 1'b1, 1'b1, 12'h000},
      '{467, 10'd35, 10'd12, 1'b0, 1'b1, 1'b1, 12'h000},
      '{468, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 12'h000},
      '{471, 10'd3,  10'd0,  1'b1, 1'b1, 1'b1, 12'h00A}
    };

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_tick", pix_tick, 1'b0);
    chk("rst_h", vga_h, 10'd0);
    chk("rst_v", vga_v, 10'd0);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_rgb", rgb_out(), 12'h000);
    release_rst();

    // Table-driven scan through one frame with ROM emulation
    for (int r = 0; r < 23; r++) begin
      while (ticks < tbl[r].tk) next_tick();
      chk($sformatf("vec%0d_h", r),     vga_h,     tbl[r].h);
      chk($sformatf("vec%0d_v", r),     vga_v,     tbl[r].v);
      chk($sformatf("vec%0d_valid", r), valid,     tbl[r].vld);
      chk($sformatf("vec%0d_hsync", r), hsync,     tbl[r].hs);
      chk($sformatf("vec%0d_vsync", r), vsync,     tbl[r].vs);
      chk($sformatf("vec%0d_rgb", r),   rgb_out(), tbl[r].rgb);
    end

    // One full line at clock resolution: hsync width, first low column, tick spacing
    for (int i = 0; i < HT + 2 && vga_h != 10'd0; i++) next_tick();
    chk("line_sync_h0", vga_h, 10'd0);
    hs_low = 0; tk_cnt = 0; first_low = -1; last_tk = -1; sp_err = 0;
    for (int i = 0; i < HT*CLK_DIV; i++) begin
      @(negedge clk);
      if (hsync == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(vga_h);
      end
      if (pix_tick) begin
        tk_cnt++;
        if (last_tk >= 0 && i - last_tk != CLK_DIV) sp_err++;
        last_tk = i;
      end
    end
    chk("line_hsync_low_clk", hs_low, HS*CLK_DIV);
    chk("line_first_low_h", first_low, HV + HF + PL + 1);
    chk("line_tick_count", tk_cnt, HT);
    chk("line_tick_spacing_err", sp_err, 0);

    // Full frame with pix_data stuck at FFF: vsync width, blanking, frame period
    for (int i = 0; i < HT*VT + 4 && !(vga_h == 10'd0 && vga_v == 10'd0); i++) next_tick();
    chk("frame_sync_h", vga_h, 10'd0);
    chk("frame_sync_v", vga_v, 10'd0);
    rom_en = 1'b0;
    pix_data = 12'hFFF;
    vs_low = 0; n_fff = 0; n_other = 0; wraps = 0;
    for (int i = 0; i < HT*VT; i++) begin
      next_tick();
      if (vsync == 1'b0) vs_low++;
      if (rgb_out() == 12'hFFF) n_fff++;
      else if (rgb_out() != 12'h000) n_other++;
      if (vga_h == 10'd0 && vga_v == 10'd0) wraps++;
    end
    chk("frame_vsync_low_ticks", vs_low, VS*HT);
    chk("frame_visible_ticks", n_fff, HV*VV);
    chk("frame_other_rgb", n_other, 0);
    chk("frame_wraps", wraps, 1);
    chk("frame_end_h", vga_h, 10'd0);
    chk("frame_end_v", vga_v, 10'd0);
    rom_en = 1'b1;

    // Async reset while both syncs are active, then clean refill
    for (int i = 0; i < HT*VT + 4 && !(vga_h == 10'd30 && vga_v == 10'd8); i++) next_tick();
    chk("mid_pre_hsync", hsync, 1'b0);
    chk("mid_pre_vsync", vsync, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_hsync", hsync, 1'b1);
    chk("mid_rst_vsync", vsync, 1'b1);
    chk("mid_rst_rgb", rgb_out(), 12'h000);
    chk("mid_rst_h", vga_h, 10'd0);
    chk("mid_rst_v", vga_v, 10'd0);
    repeat (2) @(negedge clk);
    release_rst();
    runt = 0;
    for (int j = 1; j < HV + HF + PL + 1; j++) begin
      next_tick();
      if (hsync == 1'b0 || vsync == 1'b0) runt++;
    end
    chk("mid_no_runt", runt, 0);
    chk("mid_rgb_first_pixel", rgb_out(), 12'h000);
    next_tick();
    chk("mid_first_low_h", vga_h, 10'd27);
    chk("mid_first_low_hsync", hsync, 1'b0);

`ifdef VGA_FRAME_CNT_EN
    begin
      int fs_clk, fs_rise;
      bit prev, got;
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("fc_rst_cnt", frame_cnt, 16'd0);
      release_rst();
      fs_clk = 0; fs_rise = 0; prev = 1'b0;
      for (int i = 0; i < 3*HT*VT*CLK_DIV + 8; i++) begin
        @(negedge clk);
        if (frame_start) fs_clk++;
        if (frame_start && !prev) fs_rise++;
        prev = frame_start;
      end
      chk("fc_pulses", fs_rise, 3);
      chk("fc_pulse_clks", fs_clk, 3);
      chk("fc_count3", frame_cnt, 16'd3);
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      got = 1'b0;
      for (int i = 0; i < (HT*VT + 4)*CLK_DIV && !got; i++) begin
        @(negedge clk);
        if (frame_start) got = 1'b1;
      end
      chk("fc_wrap_seen", got, 1'b1);
      @(posedge clk); #1;
      chk("fc_wrap_zero", frame_cnt, 16'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
